// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and sizing helpers for word_serializer.
package serializer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int DEFAULT_WIDTH = 6;
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/word_serializer.sv
// word_serializer: accepts a parallel word over valid/ready and emits it one bit per clock.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             shift_in,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_data, w_data;
  logic [CW-1:0]    r_cnt, w_cnt, w_idx;
  logic [3:0]       r_gap, w_gap;
  logic             r_load_ready, r_shift_in, r_bit_valid, r_word_done, r_busy;
  logic             w_accept, w_last, w_bv, w_done;
  always_comb begin
    w_accept = load_valid && r_load_ready;
    w_last   = (r_state == SHIFT) && (r_cnt == LAST);
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_gap    = r_gap;
    w_data   = w_accept ? load_data : r_data;
    if (w_accept) begin
      w_state = SHIFT;
      w_cnt   = '0;
    end else if (r_state == SHIFT) begin
      w_cnt   = w_last ? '0 : r_cnt + CW'(1);
      w_state = !w_last ? SHIFT : (GAP_CYCLES > 0 ? GAP : IDLE);
      w_gap   = '0;
    end else if (r_state == GAP) begin
      w_gap   = r_gap + 4'd1;
      w_state = (r_gap == GAP_LAST) ? IDLE : GAP;
    end
    // Outputs are precomputed from the next state so they can be registered.
    w_idx  = (LSB_FIRST != 0) ? w_cnt : LAST - w_cnt;
    w_bv   = (w_state == SHIFT);
    w_done = w_bv && (w_cnt == LAST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_data       <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_load_ready <= 1'b1;
      r_shift_in   <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_word_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_data       <= w_data;
      r_cnt        <= w_cnt;
      r_gap        <= w_gap;
      r_load_ready <= (w_state == IDLE) || (GAP_CYCLES == 0 && w_done);
      r_shift_in   <= w_bv && w_data[w_idx];
      r_bit_valid  <= w_bv;
      r_word_done  <= w_done;
      r_busy       <= (w_state != IDLE);
    end
  end
  assign load_ready = r_load_ready;
  assign shift_in   = r_shift_in;
  assign bit_valid  = r_bit_valid;
  assign word_done  = r_word_done;
  assign busy       = r_busy;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed checks of LSB/MSB order, back-to-back, gap, busy-ignore and reset.
module tb_word_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lv [3];
  logic [5:0] ld [3];
  logic       lr [3], so [3], bv [3], wd [3], by [3];
  logic [5:0] sr1 = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(6), .LSB_FIRST(1), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .reset(reset), .load_data(ld[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .shift_in(so[0]), .bit_valid(bv[0]), .word_done(wd[0]), .busy(by[0]));
  word_serializer #(.WIDTH(6), .LSB_FIRST(0), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .reset(reset), .load_data(ld[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .shift_in(so[1]), .bit_valid(bv[1]), .word_done(wd[1]), .busy(by[1]));
  word_serializer #(.WIDTH(6), .LSB_FIRST(1), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .reset(reset), .load_data(ld[2]), .load_valid(lv[2]), .load_ready(lr[2]),
    .shift_in(so[2]), .bit_valid(bv[2]), .word_done(wd[2]), .busy(by[2]));

  // Downstream 6-bit shift register fed by the MSB-first instance.
  always @(posedge clk) if (bv[1]) sr1 <= {sr1[4:0], so[1]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int d, input string tag);
    chk({tag, ".ready"}, lr[d], 1'b1);
    chk({tag, ".shift"}, so[d], 1'b0);
    chk({tag, ".valid"}, bv[d], 1'b0);
    chk({tag, ".done"}, wd[d], 1'b0);
    chk({tag, ".busy"}, by[d], 1'b0);
  endtask

  task automatic word_chk(input int d, input logic [5:0] w, input bit msb,
                          input bit last_ready, input bit poke, input string tag);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s.bit%0d", tag, k), so[d], w[msb ? 5 - k : k]);
      chk($sformatf("%s.valid%0d", tag, k), bv[d], 1'b1);
      chk($sformatf("%s.done%0d", tag, k), wd[d], k == 5);
      chk($sformatf("%s.ready%0d", tag, k), lr[d], (k == 5) ? last_ready : 1'b0);
      chk($sformatf("%s.busy%0d", tag, k), by[d], 1'b1);
      if (poke && k == 1) begin
        ld[d] = 6'b111111;
        lv[d] = 1'b1;
      end
      if (poke && k == 2) lv[d] = 1'b0;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) idle_chk(i, $sformatf("rst%0d", i));
    reset = 1'b0;
    tick();

    ld[0] = 6'b101101; lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    word_chk(0, 6'b101101, 1'b0, 1'b1, 1'b0, "lsb");
    idle_chk(0, "lsb_after");

    ld[1] = 6'b110010; lv[1] = 1'b1;
    tick();
    lv[1] = 1'b0;
    word_chk(1, 6'b110010, 1'b1, 1'b1, 1'b0, "msb");
    idle_chk(1, "msb_after");
    chk("msb.downstream", sr1 === 6'b110010, 1'b1);

    ld[0] = 6'b000111; lv[0] = 1'b1;
    tick();
    ld[0] = 6'b111000;
    word_chk(0, 6'b000111, 1'b0, 1'b1, 1'b0, "b2b_a");
    lv[0] = 1'b0;
    word_chk(0, 6'b111000, 1'b0, 1'b1, 1'b0, "b2b_b");
    idle_chk(0, "b2b_after");

    ld[2] = 6'b011001; lv[2] = 1'b1;
    tick();
    ld[2] = 6'b100110;
    word_chk(2, 6'b011001, 1'b0, 1'b0, 1'b0, "gap_a");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("gap%0d.valid", g), bv[2], 1'b0);
      chk($sformatf("gap%0d.ready", g), lr[2], 1'b0);
      chk($sformatf("gap%0d.shift", g), so[2], 1'b0);
      chk($sformatf("gap%0d.busy", g), by[2], 1'b1);
      tick();
    end
    idle_chk(2, "gap_idle");
    tick();
    lv[2] = 1'b0;
    word_chk(2, 6'b100110, 1'b0, 1'b0, 1'b0, "gap_b");

    ld[0] = 6'b010011; lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    word_chk(0, 6'b010011, 1'b0, 1'b1, 1'b1, "busy_ign");
    idle_chk(0, "busy_ign_after");

    ld[0] = 6'b101010; lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rmid.bit%0d", k), so[0], k[0]);
      chk($sformatf("rmid.valid%0d", k), bv[0], 1'b1);
      if (k < 2) tick();
    end
    reset = 1'b1; lv[0] = 1'b1;
    tick();
    idle_chk(0, "rmid_rst");
    tick();
    idle_chk(0, "rmid_rst_valid");
    reset = 1'b0;
    tick();
    lv[0] = 1'b0;
    word_chk(0, 6'b101010, 1'b0, 1'b1, 1'b0, "rmid_new");
    idle_chk(0, "rmid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial loader that sits directly upstream of the 6-bit serial-in shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it one bit per clock onto the register's serial input.
- Flags valid bits and end-of-word so the downstream stage can sample a full word.

Parameters:
- WIDTH, 6, word length in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
- GAP_CYCLES, 0, idle cycles inserted after each word before a new word can be accepted; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- shift_in  output  1  serial bit to the downstream register.
- bit_valid  output  1  shift_in carries a real data bit this cycle.
- word_done  output  1  one-cycle pulse, coincident with the last bit of a word.
- busy  output  1  high while in SHIFT or GAP.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: load_ready=1, shift_in=0, bit_valid=0, word_done=0, busy=0, bit counter=0, state=IDLE.
- All outputs are registered.
- Accept condition: load_valid && load_ready at a rising edge. load_data is copied into a holding register at that edge. Later changes to load_data have no effect on the word in flight.
- States:
  - IDLE: load_ready=1. On accept, go to SHIFT.
  - SHIFT: bit_valid=1 for exactly WIDTH consecutive cycles.
  - GAP: only when GAP_CYCLES>0. Counts GAP_CYCLES cycles, then returns to IDLE.
- Latency: the first bit appears on shift_in in the cycle after the accept edge.
- Bit order:
  - LSB_FIRST=1: bit k appears k cycles after the first bit.
  - LSB_FIRST=0: bit WIDTH-1-k appears k cycles after the first bit.
- word_done=1 only in the cycle carrying the final bit.
- After the final bit:
  - GAP_CYCLES>0: go to GAP.
  - GAP_CYCLES=0: go to IDLE, unless a new word is accepted in the final-bit cycle (see back-to-back).
- Back-to-back (GAP_CYCLES=0): load_ready is also high during the final SHIFT cycle. An accept there starts the next word on the very next cycle, so bit_valid never drops between words.
- In all other SHIFT and GAP cycles, load_ready=0. load_valid is ignored there and no data is captured.
- Whenever bit_valid=0, shift_in=0.
- Bit counter is clog2(WIDTH) bits wide. It counts 0..WIDTH-1 and resets to 0 on every accept. It must never exceed WIDTH-1.
- Reset asserted mid-word or mid-gap: the next edge returns to IDLE with all reset values. The partial word is discarded and no word_done is emitted.
- Reset and load_valid high in the same cycle: reset wins and no word is accepted.

Decomposition:
- Shared package serializer_pkg holds:
  - state typedef (IDLE, SHIFT, GAP);
  - constant DEFAULT_WIDTH=6;
  - a width helper function for counter sizing.
- No sub-module. The counter, holding register and FSM fit in one module.

Test Plan:
- Basic LSB-first: WIDTH=6, LSB_FIRST=1. Accept 6'b101101 at edge T.
  - Required: shift_in = 1,0,1,1,0,1 on cycles T+1..T+6.
  - bit_valid high for those 6 cycles only.
  - word_done only at T+6; load_ready=0 from T+1..T+5.
- MSB-first: LSB_FIRST=0. Accept 6'b110010.
  - Required: shift_in = 1,1,0,0,1,0.
  - Downstream register then holds 6'b110010 with the same shift direction convention.
- Back-to-back: GAP_CYCLES=0, load_valid held high with 6'b000111 then 6'b111000.
  - Required: 12 contiguous bit_valid cycles.
  - Second word accepted in the word_done cycle.
  - Two word_done pulses, 6 cycles apart.
- Gap: GAP_CYCLES=2, load_valid held high.
  - Required: after word_done, bit_valid=0 and load_ready=0 for 2 cycles.
  - Then load_ready=1 for one cycle; the next word's first bit follows one cycle after that accept.
- Busy-ignore: during SHIFT, change load_data to 6'b111111 and pulse load_valid.
  - Required: the in-flight word is unchanged and no extra accept occurs.
- Reset mid-word: assert reset after the 3rd bit of 6'b101010.
  - Required: next cycle all outputs at reset values, no word_done.
  - A new word accepted after deassert is transmitted complete and correct.
